// File: rtl/axi_burst_rd_slave.sv
// AXI4 burst read slave backed by an internal word array.
//
// One read is outstanding at a time: IDLE accepts an AR, RESP streams arlen+1
// beats at up to one beat per cycle, then returns to IDLE. Supports FIXED,
// INCR and WRAP bursts of 64-bit beats. Unsupported requests (arsize!=3,
// burst type 11, or an illegal WRAP length) answer every beat with SLVERR;
// beats that fall outside the array answer DECERR. A backdoor write port
// preloads the array one word per cycle.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   s_axi_ar*             read address channel (slave side)
//   s_axi_r*              read data channel (slave side)
//   wr_en/wr_addr/wr_data backdoor word write (byte address, 64-bit data)
module axi_burst_rd_slave #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_WORDS  = 512,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(64'h0)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  localparam int IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES  = ADDR_WIDTH'(MEM_WORDS * 8);
  localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(7);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {IDLE, RESP} state_t;

  // Byte address lands inside the array (below-base addresses are excluded
  // explicitly, since the subtraction would wrap).
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < MEM_BYTES);
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IW'((a - BASE_ADDR) >> 3);
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt, ld_addr, span, bound;
  logic [7:0]            len_q, beat_q;
  logic [1:0]            burst_q;
  logic                  err_q, ar_err, ld_err, ld_last;
  logic                  ar_hs, r_hs, ld_more;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [1:0]            ld_resp;

  assign ar_hs   = s_axi_arvalid & s_axi_arready;
  assign r_hs    = s_axi_rvalid & s_axi_rready;
  assign ld_more = r_hs & ~s_axi_rlast;

  assign ar_err = (s_axi_arsize != 3'd3) || (s_axi_arburst == 2'b11) ||
                  ((s_axi_arburst == 2'b10) &&
                   !(s_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

  // Address of the beat after the one currently presented.
  always_comb begin
    span     = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << 3;
    bound    = addr_q & ~(span - ADDR_WIDTH'(1));
    addr_nxt = addr_q + WORD_BYTES;
    case (burst_q)
      2'b00:   addr_nxt = addr_q;
      2'b10:   if ((addr_q + WORD_BYTES) == (bound + span)) addr_nxt = bound;
      default: addr_nxt = addr_q + WORD_BYTES;
    endcase
  end

  // Beat loader: either the first beat at AR handshake or the next beat when
  // a non-final beat completes. Reading the array here, ahead of the clock
  // edge that performs any backdoor write, gives read-before-write behaviour.
  always_comb begin
    ld_addr = ar_hs ? (s_axi_araddr & ALIGN_MASK) : addr_nxt;
    ld_err  = ar_hs ? ar_err : err_q;
    ld_last = ar_hs ? (s_axi_arlen == 8'd0) : ((beat_q + 8'd1) == len_q);
    ld_data = '0;
    ld_resp = RESP_OKAY;
    if (ld_err) begin
      ld_resp = RESP_SLVERR;
    end else if (!in_range(ld_addr)) begin
      ld_resp = RESP_DECERR;
    end else begin
      ld_data = mem[word_idx(ld_addr)];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ar_hs) state_nxt = RESP;
      RESP:    if (r_hs && s_axi_rlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // arready/rvalid are registered from the next state so that both are low
  // throughout reset and arready rises on the first edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      burst_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      state         <= state_nxt;
      s_axi_arready <= (state_nxt == IDLE);
      s_axi_rvalid  <= (state_nxt == RESP);
      if (ar_hs) begin
        s_axi_rid <= s_axi_arid;
        len_q     <= s_axi_arlen;
        burst_q   <= s_axi_arburst;
        err_q     <= ar_err;
        beat_q    <= '0;
      end else if (ld_more) begin
        beat_q    <= beat_q + 8'd1;
      end
      // Output beat registers only change on a load, so they hold through
      // rready stalls and are immune to later backdoor writes.
      if (ar_hs || ld_more) begin
        addr_q      <= ld_addr;
        s_axi_rdata <= ld_data;
        s_axi_rresp <= ld_resp;
        s_axi_rlast <= ld_last;
      end
    end
  end

  // Array has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_en && in_range(wr_addr)) mem[word_idx(wr_addr)] <= wr_data;
  end

endmodule

// File: tb/tb_axi_burst_rd_slave.sv
module tb_axi_burst_rd_slave;
  localparam int IDW = 13;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int MW  = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [IDW-1:0] s_axi_arid;
  logic [AW-1:0]  s_axi_araddr;
  logic [7:0]     s_axi_arlen;
  logic [2:0]     s_axi_arsize;
  logic [1:0]     s_axi_arburst;
  logic           s_axi_arvalid;
  logic           s_axi_arready;
  logic [IDW-1:0] s_axi_rid;
  logic [DW-1:0]  s_axi_rdata;
  logic [1:0]     s_axi_rresp;
  logic           s_axi_rlast;
  logic           s_axi_rvalid;
  logic           s_axi_rready;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;

  axi_burst_rd_slave dut (
    .clk(clk), .reset(reset),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] mdl [MW];

  typedef struct {
    logic [IDW-1:0] id;
    logic [63:0]    addr;
    logic [7:0]     len;
    logic [2:0]     size;
    logic [1:0]     burst;
    int             mode;   // 0: rready=1, 1: rready 1,0,0,1 pattern, 2: random
    logic [63:0]    fd;
    logic [1:0]     fr;
    logic [63:0]    ld;
    logic [1:0]     lr;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic ok, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic wr_word(input logic [63:0] a, input logic [63:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (a < 64'(MW * 8)) mdl[a >> 3] = d;
  endtask

  // Reference: beat k of a burst, from the addressing rules directly.
  function automatic void exp_beat(input logic [63:0] start, input logic [7:0] len,
                                   input logic [2:0] size, input logic [1:0] burst,
                                   input int k, output logic [63:0] d, output logic [1:0] r);
    logic [63:0] a0, a, span, base;
    d = '0;
    if (size != 3'd3 || burst == 2'b11 ||
        (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15))) begin
      r = 2'b10;
      return;
    end
    a0 = {start[63:3], 3'b000};
    case (burst)
      2'b00:   a = a0;
      2'b01:   a = a0 + 64'(8 * k);
      default: begin
        span = (64'(len) + 64'd1) * 64'd8;
        base = a0 - (a0 % span);
        a    = base + ((a0 - base + 64'(8 * k)) % span);
      end
    endcase
    if (a >= 64'(MW * 8)) r = 2'b11;
    else begin
      d = mdl[a >> 3];
      r = 2'b00;
    end
  endfunction

  task automatic run_burst(input logic [IDW-1:0] id, input logic [63:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int mode,
                           output logic [63:0] fd, output logic [1:0] fr,
                           output logic [63:0] ld, output logic [1:0] lr);
    int beats, cyc, bad;
    logic [63:0] ed;
    logic [1:0] er;
    logic rdy, ok;
    chk("arready_before", s_axi_arready === 1'b1,
        $sformatf("arready=%b want 1", s_axi_arready));
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    beats = 0; cyc = 0; bad = 0;
    fd = '0; fr = '0; ld = '0; lr = '0;
    while (beats <= int'(len) && cyc < 200 && bad < 4) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      s_axi_rready = rdy;
      exp_beat(addr, len, size, burst, beats, ed, er);
      ok = (s_axi_rvalid === 1'b1) && (s_axi_rdata === ed) && (s_axi_rresp === er) &&
           (s_axi_rlast === (beats == int'(len))) && (s_axi_rid === id);
      chk("beat", ok, $sformatf(
          "addr=%h beat %0d cyc %0d got v=%b d=%h r=%0d l=%b id=%h want v=1 d=%h r=%0d l=%b id=%h",
          addr, beats, cyc, s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rid,
          ed, er, (beats == int'(len)), id));
      if (!ok) bad++;
      if (rdy && s_axi_rvalid === 1'b1) begin
        if (beats == 0) begin fd = s_axi_rdata; fr = s_axi_rresp; end
        ld = s_axi_rdata; lr = s_axi_rresp;
        beats++;
      end
      @(negedge clk);
      cyc++;
    end
    s_axi_rready = 1'b0;
    chk("beat_count", beats == int'(len) + 1,
        $sformatf("got %0d beats want %0d", beats, int'(len) + 1));
    chk("idle_after", s_axi_rvalid === 1'b0 && s_axi_arready === 1'b1,
        $sformatf("rvalid=%b arready=%b want 0/1", s_axi_rvalid, s_axi_arready));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] fd, ld, old8;
    logic [1:0]  fr, lr;
    logic [IDW-1:0] rid_r;
    logic [63:0] ra;
    logic [7:0]  rl;
    logic [2:0]  rs;
    logic [1:0]  rb;

    tbl[0]  = '{13'd1,    64'h0,   8'd7, 3'd3, 2'b01, 0, 64'h11, 2'd0, 64'h88, 2'd0};
    tbl[1]  = '{13'd2,    64'h28,  8'd7, 3'd3, 2'b10, 0, 64'h66, 2'd0, 64'h55, 2'd0};
    tbl[2]  = '{13'd3,    64'h0,   8'd7, 3'd3, 2'b01, 1, 64'h11, 2'd0, 64'h88, 2'd0};
    tbl[3]  = '{13'd4,    64'hFF0, 8'd3, 3'd3, 2'b01, 0, 64'hA5A5_0000_0000_01FE, 2'd0, 64'h0, 2'd3};
    tbl[4]  = '{13'd5,    64'hFF0, 8'd3, 3'd2, 2'b01, 0, 64'h0,  2'd2, 64'h0,  2'd2};
    tbl[5]  = '{13'h1ABC, 64'h10,  8'd0, 3'd3, 2'b01, 0, 64'h33, 2'd0, 64'h33, 2'd0};
    tbl[6]  = '{13'd6,    64'h18,  8'd3, 3'd3, 2'b00, 2, 64'h44, 2'd0, 64'h44, 2'd0};
    tbl[7]  = '{13'd7,    64'h0,   8'd1, 3'd3, 2'b11, 0, 64'h0,  2'd2, 64'h0,  2'd2};
    tbl[8]  = '{13'd8,    64'h0,   8'd2, 3'd3, 2'b10, 0, 64'h0,  2'd2, 64'h0,  2'd2};
    tbl[9]  = '{13'd9,    64'h7,   8'd1, 3'd3, 2'b01, 1, 64'h11, 2'd0, 64'h22, 2'd0};
    tbl[10] = '{13'd10,   64'h1000,8'd0, 3'd3, 2'b01, 0, 64'h0,  2'd3, 64'h0,  2'd3};
    tbl[11] = '{13'd11,   64'h3C,  8'd3, 3'd3, 2'b10, 0, 64'h88, 2'd0, 64'h77, 2'd0};

    reset = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", s_axi_arready === 1'b0 && s_axi_rvalid === 1'b0 &&
        s_axi_rlast === 1'b0 && s_axi_rresp === 2'd0 && s_axi_rid === '0 && s_axi_rdata === '0,
        $sformatf("ar=%b v=%b l=%b r=%0d id=%h d=%h want all 0", s_axi_arready,
                  s_axi_rvalid, s_axi_rlast, s_axi_rresp, s_axi_rid, s_axi_rdata));
    reset = 1'b1;
    @(negedge clk);
    chk("arready_after_reset", s_axi_arready === 1'b1 && s_axi_rvalid === 1'b0,
        $sformatf("arready=%b rvalid=%b want 1/0", s_axi_arready, s_axi_rvalid));

    // Preload the whole array; words 0..7 and 510 get known values.
    for (int i = 0; i < MW; i++) begin
      if (i < 8) wr_word(64'(i) * 8, 64'h11 * 64'(i + 1));
      else if (i == 510) wr_word(64'(i) * 8, 64'hA5A5_0000_0000_01FE);
      else wr_word(64'(i) * 8, {$urandom, $urandom});
    end
    // Out-of-range write must not alias onto word 0.
    wr_word(64'(MW * 8), 64'hDEAD_BEEF);

    for (int t = 0; t < 12; t++) begin
      run_burst(tbl[t].id, tbl[t].addr, tbl[t].len, tbl[t].size, tbl[t].burst,
                tbl[t].mode, fd, fr, ld, lr);
      chk($sformatf("tbl%0d_first", t), fd === tbl[t].fd && fr === tbl[t].fr,
          $sformatf("got d=%h r=%0d want d=%h r=%0d", fd, fr, tbl[t].fd, tbl[t].fr));
      chk($sformatf("tbl%0d_last", t), ld === tbl[t].ld && lr === tbl[t].lr,
          $sformatf("got d=%h r=%0d want d=%h r=%0d", ld, lr, tbl[t].ld, tbl[t].lr));
    end

    // Backdoor write in the handshake cycle returns the old word; a later
    // write during a stall must not disturb the presented beat.
    old8 = mdl[8];
    s_axi_arid = 13'd20; s_axi_araddr = 64'h40; s_axi_arlen = 8'd0;
    s_axi_arsize = 3'd3; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
    wr_en = 1'b1; wr_addr = 64'h40; wr_data = 64'h1111;
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    chk("rbw_old", s_axi_rvalid === 1'b1 && s_axi_rdata === old8,
        $sformatf("v=%b d=%h want 1/%h", s_axi_rvalid, s_axi_rdata, old8));
    wr_data = 64'h2222;
    @(negedge clk);
    wr_en = 1'b0;
    chk("stall_hold", s_axi_rvalid === 1'b1 && s_axi_rdata === old8 && s_axi_rlast === 1'b1,
        $sformatf("v=%b d=%h l=%b want 1/%h/1", s_axi_rvalid, s_axi_rdata, s_axi_rlast, old8));
    mdl[8] = 64'h2222;
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
    chk("rbw_done", s_axi_rvalid === 1'b0 && s_axi_arready === 1'b1,
        $sformatf("rvalid=%b arready=%b want 0/1", s_axi_rvalid, s_axi_arready));
    run_burst(13'd21, 64'h40, 8'd0, 3'd3, 2'b01, 0, fd, fr, ld, lr);
    chk("rbw_new", fd === 64'h2222, $sformatf("got %h want 2222", fd));

    // Reset in the middle of an 8-beat burst.
    s_axi_arid = 13'd22; s_axi_araddr = 64'h0; s_axi_arlen = 8'd7;
    s_axi_arsize = 3'd3; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_beat4", s_axi_rvalid === 1'b1 && s_axi_rdata === 64'h44,
        $sformatf("v=%b d=%h want 1/44", s_axi_rvalid, s_axi_rdata));
    reset = 1'b0;
    #1;
    chk("mid_reset", s_axi_rvalid === 1'b0 && s_axi_arready === 1'b0 &&
        s_axi_rlast === 1'b0 && s_axi_rdata === '0 && s_axi_rid === '0,
        $sformatf("v=%b ar=%b l=%b d=%h id=%h want 0s", s_axi_rvalid, s_axi_arready,
                  s_axi_rlast, s_axi_rdata, s_axi_rid));
    @(negedge clk);
    s_axi_rready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_release", s_axi_arready === 1'b1 && s_axi_rvalid === 1'b0,
        $sformatf("arready=%b rvalid=%b want 1/0", s_axi_arready, s_axi_rvalid));
    run_burst(13'd23, 64'h0, 8'd0, 3'd3, 2'b01, 0, fd, fr, ld, lr);
    chk("mid_word0", fd === 64'h11 && fr === 2'd0,
        $sformatf("got d=%h r=%0d want 11/0", fd, fr));

    // Randomized bursts against the reference model.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0)
        wr_word(64'($urandom_range(0, MW - 1)) * 8, {$urandom, $urandom});
      rid_r = IDW'($urandom);
      ra    = 64'($urandom_range(0, 600)) * 8 + 64'($urandom_range(0, 7));
      rb    = 2'($urandom_range(0, 3));
      if (rb == 2'b10 && $urandom_range(0, 3) != 0)
        rl = 8'((2 << $urandom_range(0, 3)) - 1);
      else
        rl = 8'($urandom_range(0, 15));
      rs = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
      run_burst(rid_r, ra, rl, rs, rb, 2, fd, fr, ld, lr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
